// File: rtl/saph_fpu_arbiter.sv
// saph_fpu_arbiter: round-robin sharing of one fixed-latency FPU among
// NUM_REQ requesters. A tag shift register running in lock-step with the FPU
// pipeline records the owner of each in-flight slot and steers the result back
// to it. Modes the FPU lacks never enter the FPU; they ride the tag pipe as
// error entries so that responses stay in issue order.
module saph_fpu_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int LATENCY = 2,
    parameter int FW      = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_REQ-1:0]   req_valid,
    output logic [NUM_REQ-1:0]   req_ready,
    input  logic [2*NUM_REQ-1:0] req_mode,
    input  logic [FW*NUM_REQ-1:0] req_lhs,
    input  logic [FW*NUM_REQ-1:0] req_rhs,
    output logic [NUM_REQ-1:0]   resp_valid,
    output logic                 resp_err,
    output logic [FW-1:0]        resp_res,
    output logic                 fpu_d_trig,
    output logic [1:0]           fpu_d_mode,
    output logic [FW-1:0]        fpu_d_lhs,
    output logic [FW-1:0]        fpu_d_rhs,
    input  logic                 fpu_d_ready,
    input  logic [3:0]           fpu_has_modes,
    input  logic                 fpu_q_trig,
    input  logic [FW-1:0]        fpu_q_res,
    output logic                 err_desync
);

    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int PL = (LATENCY > 0) ? LATENCY : 1;

    logic [IW-1:0] ptr_r;
    logic          win_found_s;
    logic [IW-1:0] win_idx_s;
    logic [1:0]    win_mode_s;
    logic [FW-1:0] win_lhs_s;
    logic [FW-1:0] win_rhs_s;
    logic          xfer_s;
    logic          unsup_s;
    logic [IW-1:0] ptr_next_s;
    logic          fin_v_s;
    logic          fin_e_s;
    logic [IW-1:0] fin_i_s;
    logic          exp_q_s;
    logic          err_desync_r;

    // Winner search: first valid requester at or after the pointer, wrapping.
    always_comb begin
        int cand;
        win_found_s = 1'b0;
        win_idx_s   = {IW{1'b0}};
        cand        = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = int'(ptr_r) + i;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end else begin
                cand = cand;
            end
            if (!win_found_s && req_valid[cand]) begin
                win_found_s = 1'b1;
                win_idx_s   = IW'(cand);
            end else begin
                win_found_s = win_found_s;
            end
        end
    end

    // Winner's operation fields; zero when nobody is requesting.
    always_comb begin
        if (win_found_s) begin
            win_mode_s = req_mode[int'(win_idx_s)*2 +: 2];
            win_lhs_s  = req_lhs[int'(win_idx_s)*FW +: FW];
            win_rhs_s  = req_rhs[int'(win_idx_s)*FW +: FW];
        end else begin
            win_mode_s = 2'b00;
            win_lhs_s  = {FW{1'b0}};
            win_rhs_s  = {FW{1'b0}};
        end
    end

    // Transfer qualification; everything is held off while reset is asserted.
    always_comb begin
        xfer_s  = rst_n & win_found_s & fpu_d_ready;
        unsup_s = ~fpu_has_modes[win_mode_s];
        if (win_idx_s == IW'(NUM_REQ - 1)) begin
            ptr_next_s = {IW{1'b0}};
        end else begin
            ptr_next_s = win_idx_s + IW'(1);
        end
    end

    // Accept goes only to the winner and simply mirrors FPU readiness.
    always_comb begin
        req_ready = {NUM_REQ{1'b0}};
        if (rst_n && win_found_s) begin
            req_ready[win_idx_s] = fpu_d_ready;
        end else begin
            req_ready = {NUM_REQ{1'b0}};
        end
    end

    // Issue side toward the FPU; unsupported modes complete without a trigger.
    always_comb begin
        fpu_d_trig = xfer_s & ~unsup_s;
        fpu_d_mode = win_mode_s;
        fpu_d_lhs  = win_lhs_s;
        fpu_d_rhs  = win_rhs_s;
    end

    // Round-robin pointer: advance past the winner on every transfer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_r <= {IW{1'b0}};
        end else if (xfer_s) begin
            ptr_r <= ptr_next_s;
        end else begin
            ptr_r <= ptr_r;
        end
    end

    generate
        if (LATENCY > 0) begin : g_pipe
            logic [PL-1:0] tv_r;
            logic [PL-1:0] te_r;
            logic [IW-1:0] ti_r [PL];

            // Tag shift register; never stalls because the FPU is fixed-latency.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    tv_r <= {PL{1'b0}};
                    te_r <= {PL{1'b0}};
                    for (int s = 0; s < PL; s++) begin
                        ti_r[s] <= {IW{1'b0}};
                    end
                end else begin
                    tv_r[0] <= xfer_s;
                    te_r[0] <= unsup_s;
                    ti_r[0] <= win_idx_s;
                    for (int s = 1; s < PL; s++) begin
                        tv_r[s] <= tv_r[s-1];
                        te_r[s] <= te_r[s-1];
                        ti_r[s] <= ti_r[s-1];
                    end
                end
            end

            assign fin_v_s = tv_r[PL-1];
            assign fin_e_s = te_r[PL-1];
            assign fin_i_s = ti_r[PL-1];
        end else begin : g_bypass
            assign fin_v_s = xfer_s;
            assign fin_e_s = unsup_s;
            assign fin_i_s = win_idx_s;
        end
    endgenerate

    // Response steering from the final tag stage.
    always_comb begin
        resp_valid = {NUM_REQ{1'b0}};
        if (fin_v_s) begin
            resp_valid[fin_i_s] = 1'b1;
        end else begin
            resp_valid = {NUM_REQ{1'b0}};
        end
        resp_err = fin_v_s & fin_e_s;
        if (fin_v_s && !fin_e_s) begin
            resp_res = fpu_q_res;
        end else begin
            resp_res = {FW{1'b0}};
        end
        exp_q_s = fin_v_s & ~fin_e_s;
    end

    // Sticky flag: the FPU result strobe disagreed with what the tags predict.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_desync_r <= 1'b0;
        end else if (fpu_q_trig != exp_q_s) begin
            err_desync_r <= 1'b1;
        end else begin
            err_desync_r <= err_desync_r;
        end
    end

    assign err_desync = err_desync_r;

endmodule
